writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage.sv | 116 +++++++++++
 tb/tb_writeback_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: a 2-entry in-order retirement buffer in front of the
// architectural register file, with two forwarding read ports.
module writeback_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_we,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_data,

    input  logic              halt,

    input  logic [REG_AW-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic [REG_AW-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data2,

    output logic              wb_valid,
    output logic [DATA_W-1:0] result,
    output logic [31:0]       retire_count
);

    localparam int NREG = 1 << REG_AW;

    logic [DATA_W-1:0] regfile [NREG];

    // Slot 0 is always the head (oldest), slot 1 the younger entry.
    logic [1:0]        count;
    logic [1:0]        slot_we;
    logic [REG_AW-1:0] slot_rd   [2];
    logic [DATA_W-1:0] slot_data [2];

    logic accept;
    logic retire_fire;
    logic head_writes;

    assign ex_ready    = (count < 2'd2);
    assign accept      = ex_valid && ex_ready;
    assign retire_fire = (count != 2'd0) && !halt;
    assign wb_valid    = retire_fire;
    assign head_writes = slot_we[0] && (slot_rd[0] != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            slot_we      <= '0;
            result       <= '0;
            retire_count <= '0;
            for (int i = 0; i < NREG; i++) begin
                regfile[i] <= '0;
            end
        end else begin
            if (retire_fire) begin
                retire_count <= retire_count + 32'd1;
                if (head_writes) begin
                    regfile[slot_rd[0]] <= slot_data[0];
                    result              <= slot_data[0];
                end
            end

            // Accept with a full buffer is impossible, so a simultaneous
            // accept and retire always happens with exactly one entry held.
            if (accept && retire_fire) begin
                slot_we[0]   <= ex_we;
                slot_rd[0]   <= ex_rd;
                slot_data[0] <= ex_data;
            end else if (accept) begin
                if (count == 2'd0) begin
                    slot_we[0]   <= ex_we;
                    slot_rd[0]   <= ex_rd;
                    slot_data[0] <= ex_data;
                end else begin
                    slot_we[1]   <= ex_we;
                    slot_rd[1]   <= ex_rd;
                    slot_data[1] <= ex_data;
                end
                count <= count + 2'd1;
            end else if (retire_fire) begin
                slot_we[0]   <= slot_we[1];
                slot_rd[0]   <= slot_rd[1];
                slot_data[0] <= slot_data[1];
                count        <= count - 2'd1;
            end
        end
    end

    logic [REG_AW-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];

    assign rd_addr[0] = rd_addr1;
    assign rd_addr[1] = rd_addr2;
    assign rd_data1   = rd_data[0];
    assign rd_data2   = rd_data[1];

    // Later matches override earlier ones so the youngest buffered write wins.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = regfile[rd_addr[p]];
            if ((count != 2'd0) && slot_we[0] && (slot_rd[0] == rd_addr[p])) begin
                rd_data[p] = slot_data[0];
            end
            if ((count == 2'd2) && slot_we[1] && (slot_rd[1] == rd_addr[p])) begin
                rd_data[p] = slot_data[1];
            end
            if (rd_addr[p] == '0) begin
                rd_data[p] = '0;
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: random and directed traffic against a queue-based
// reference model, with a retirement monitor acting as the scoreboard.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic        ex_we = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic [31:0] ex_data = '0;
    logic        halt = 1'b0;
    logic [4:0]  rd_addr1 = '0;
    logic [31:0] rd_data1;
    logic [4:0]  rd_addr2 = '0;
    logic [31:0] rd_data2;
    logic        wb_valid;
    logic [31:0] result;
    logic [31:0] retire_count;

    always #5 clk = ~clk;

    writeback_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_we        (ex_we),
        .ex_rd        (ex_rd),
        .ex_data      (ex_data),
        .halt         (halt),
        .rd_addr1     (rd_addr1),
        .rd_data1     (rd_data1),
        .rd_addr2     (rd_addr2),
        .rd_data2     (rd_data2),
        .wb_valid     (wb_valid),
        .result       (result),
        .retire_count (retire_count)
    );

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    // Model: buffered results in program order, plus architectural state.
    ent_t        exp_q[$];
    logic [31:0] ref_rf [32];
    logic [31:0] exp_result  = '0;
    logic [31:0] exp_retired = '0;
    bit          mon_en = 1'b0;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].we && exp_q[i].rd == a) return exp_q[i].data;
        end
        return ref_rf[a];
    endfunction

    task automatic flush_model();
        exp_q.delete();
        for (int i = 0; i < 32; i++) ref_rf[i] = '0;
        exp_result  = '0;
        exp_retired = '0;
    endtask

    // One clock cycle: drive after the edge, check combinational outputs mid-cycle.
    task automatic step(input bit r, input bit v, input bit w, input logic [4:0] rd,
                        input logic [31:0] d, input bit h,
                        input logic [4:0] a1, input logic [4:0] a2);
        @(posedge clk);
        #1;
        rst = r; ex_valid = v; ex_we = w; ex_rd = rd; ex_data = d;
        halt = h; rd_addr1 = a1; rd_addr2 = a2;
        @(negedge clk);
        if (r) begin
            flush_model();
        end else begin
            check("ex_ready", {31'd0, ex_ready}, {31'd0, exp_q.size() < 2});
            check("wb_valid", {31'd0, wb_valid}, {31'd0, (exp_q.size() != 0) && !h});
            check("rd_data1", rd_data1, ref_read(a1));
            check("rd_data2", rd_data2, ref_read(a2));
            if (v && exp_q.size() < 2) exp_q.push_back('{w, rd, d});
        end
    endtask

    task automatic idle(input bit h, input logic [4:0] a1, input logic [4:0] a2);
        step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, h, a1, a2);
    endtask

    // Scoreboard monitor: consumes the oldest expected entry whenever the DUT retires.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && !rst && wb_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL retire_source at %0t: got retirement expected empty buffer", $time);
                end else begin
                    e = exp_q.pop_front();
                    exp_retired = exp_retired + 32'd1;
                    if (e.we && e.rd != 5'd0) begin
                        exp_result  = e.data;
                        ref_rf[e.rd] = e.data;
                    end
                end
            end
            @(posedge clk);
            #2;
            if (mon_en) begin
                check("result", result, exp_result);
                check("retire_count", retire_count, exp_retired);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog at %0t: got timeout expected completion", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] rnd_reg();
        logic [31:0] r;
        r = $urandom();
        if (r[31]) return 5'($urandom_range(0, 7));
        return r[4:0];
    endfunction

    initial begin
        flush_model();
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        mon_en = 1'b1;
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);

        // Single write to x5, retiring one cycle after accept
        step(1'b0, 1'b1, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd5, 5'd0);
        idle(1'b0, 5'd5, 5'd5);
        idle(1'b0, 5'd5, 5'd0);

        // Halted: third back-to-back offer must be refused, then in-order drain
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        step(1'b0, 1'b1, 1'b1, 5'd1, 32'h0000_0011, 1'b1, 5'd1, 5'd2);
        step(1'b0, 1'b1, 1'b1, 5'd2, 32'h0000_0022, 1'b1, 5'd1, 5'd2);
        step(1'b0, 1'b1, 1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd3, 5'd2);
        idle(1'b0, 5'd1, 5'd2);
        idle(1'b0, 5'd1, 5'd2);
        idle(1'b0, 5'd3, 5'd2);

        // Two buffered writes to x7: the younger one forwards
        step(1'b0, 1'b1, 1'b1, 5'd7, 32'h0000_000A, 1'b1, 5'd0, 5'd7);
        step(1'b0, 1'b1, 1'b1, 5'd7, 32'h0000_000B, 1'b1, 5'd0, 5'd7);
        idle(1'b1, 5'd7, 5'd7);
        idle(1'b0, 5'd7, 5'd7);
        idle(1'b0, 5'd7, 5'd7);
        idle(1'b0, 5'd7, 5'd7);

        // Write to x0 counts as a retirement but changes nothing
        step(1'b0, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd7);
        idle(1'b0, 5'd0, 5'd0);
        idle(1'b0, 5'd0, 5'd7);

        // Simultaneous accept and retire with one entry held
        step(1'b0, 1'b1, 1'b1, 5'd12, 32'hC0DE_0001, 1'b1, 5'd12, 5'd13);
        step(1'b0, 1'b1, 1'b1, 5'd13, 32'hC0DE_0002, 1'b0, 5'd12, 5'd13);
        idle(1'b0, 5'd12, 5'd13);
        idle(1'b0, 5'd12, 5'd13);

        // Reset with two entries buffered and an offer on the reset edge
        step(1'b0, 1'b1, 1'b1, 5'd9,  32'h9999_9999, 1'b1, 5'd9, 5'd10);
        step(1'b0, 1'b1, 1'b1, 5'd10, 32'hAAAA_AAAA, 1'b1, 5'd9, 5'd10);
        step(1'b1, 1'b1, 1'b1, 5'd11, 32'hBBBB_BBBB, 1'b0, 5'd9, 5'd10);
        idle(1'b0, 5'd9, 5'd10);
        idle(1'b0, 5'd11, 5'd12);

        // Randomised traffic with occasional mid-operation resets
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 99) < 70),
                 ($urandom_range(0, 99) < 75),
                 rnd_reg(),
                 $urandom(),
                 ($urandom_range(0, 99) < 30),
                 rnd_reg(),
                 rnd_reg());
        end

        for (int n = 0; n < 4; n++) idle(1'b0, rnd_reg(), rnd_reg());
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        idle(1'b0, 5'd0, 5'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
